// File: rtl/gshare_branch_predictor_pkg.sv
// rtl/gshare_branch_predictor_pkg.sv - shared encodings for the gshare predictor and its BTB
package gshare_branch_predictor_pkg;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    localparam logic [1:0] PHT_RESET = CTR_WNT;

    typedef enum logic [1:0] {
        KIND_BR   = 2'd0,
        KIND_JAL  = 2'd1,
        KIND_JALR = 2'd2
    } btb_kind_e;

    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
        end
        return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    endfunction

    function automatic logic ctr_predicts_taken(input logic [1:0] ctr);
        return (ctr == CTR_WT) || (ctr == CTR_ST);
    endfunction

endpackage

// File: rtl/btb_array.sv
// rtl/btb_array.sv - direct-mapped BTB storage with tag compare and one write port
module btb_array
    import gshare_branch_predictor_pkg::*;
#(
    parameter int PC_WIDTH = 32,
    parameter int ENTRIES  = 32,
    parameter int IDX      = $clog2(ENTRIES),
    parameter int TAG_W    = PC_WIDTH - IDX - 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IDX-1:0]      rd_idx_i,
    input  logic [TAG_W-1:0]    rd_tag_i,
    output logic                rd_hit_o,
    output logic [PC_WIDTH-1:0] rd_target_o,
    output btb_kind_e           rd_kind_o,
    input  logic                wr_en_i,
    input  logic [IDX-1:0]      wr_idx_i,
    input  logic [TAG_W-1:0]    wr_tag_i,
    input  logic [PC_WIDTH-1:0] wr_target_i,
    input  btb_kind_e           wr_kind_i
);

    logic                valid_q  [ENTRIES];
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [PC_WIDTH-1:0] target_q [ENTRIES];
    btb_kind_e           kind_q   [ENTRIES];

    // Reads see the pre-edge contents; a same-cycle write is not bypassed.
    assign rd_hit_o    = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
    assign rd_target_o = target_q[rd_idx_i];
    assign rd_kind_o   = kind_q[rd_idx_i];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Payload needs no reset: it is only observed through a valid bit.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]    <= wr_tag_i;
            target_q[wr_idx_i] <= wr_target_i;
            kind_q[wr_idx_i]   <= wr_kind_i;
        end
    end

endmodule

// File: rtl/gshare_branch_predictor.sv
// rtl/gshare_branch_predictor.sv - BTB + gshare fetch predictor with EX-stage resolver
module gshare_branch_predictor
    import gshare_branch_predictor_pkg::*;
#(
    parameter int PC_WIDTH    = 32,
    parameter int BTB_ENTRIES = 32,
    parameter int GHR_BITS    = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PC_WIDTH-1:0] if_pc,
    output logic [PC_WIDTH-1:0] pred_next_pc,
    output logic                pred_taken,
    output logic [GHR_BITS-1:0] pred_pht_idx,
    input  logic                ex_valid,
    input  logic [PC_WIDTH-1:0] ex_pc,
    input  logic                ex_is_branch,
    input  logic                ex_is_jal,
    input  logic                ex_is_jalr,
    input  logic                ex_bcond,
    input  logic [PC_WIDTH-1:0] ex_pc_imm,
    input  logic [PC_WIDTH-1:0] ex_alu_result,
    input  logic [GHR_BITS-1:0] ex_pht_idx,
    input  logic [PC_WIDTH-1:0] ex_next_inst_pc,
    output logic                pc_src,
    output logic [PC_WIDTH-1:0] correct_pc,
    output logic                is_actually_taken,
    output logic [PC_WIDTH-1:0] rd_data,
    output logic [31:0]         mispredict_count
);

    localparam int IDX         = $clog2(BTB_ENTRIES);
    localparam int TAG_W       = PC_WIDTH - IDX - 2;
    localparam int PHT_ENTRIES = 1 << GHR_BITS;
    localparam logic [PC_WIDTH-1:0] JALR_MASK = {{(PC_WIDTH-1){1'b1}}, 1'b0};

    logic [1:0]          pht_q [PHT_ENTRIES];
    logic [GHR_BITS-1:0] ghr_q, ghr_d;
    logic [31:0]         cnt_q, cnt_d;

    logic                btb_hit;
    logic [PC_WIDTH-1:0] btb_target;
    btb_kind_e           btb_kind;
    logic [GHR_BITS-1:0] if_pht_idx;

    logic [PC_WIDTH-1:0] pc_4, ex_target;
    logic                ex_taken, is_ctrl, do_update;
    btb_kind_e           ex_kind;

    btb_array #(
        .PC_WIDTH (PC_WIDTH),
        .ENTRIES  (BTB_ENTRIES)
    ) u_btb (
        .clk         (clk),
        .rst_n       (reset),
        .rd_idx_i    (if_pc[IDX+1:2]),
        .rd_tag_i    (if_pc[PC_WIDTH-1:IDX+2]),
        .rd_hit_o    (btb_hit),
        .rd_target_o (btb_target),
        .rd_kind_o   (btb_kind),
        .wr_en_i     (do_update && ex_taken),
        .wr_idx_i    (ex_pc[IDX+1:2]),
        .wr_tag_i    (ex_pc[PC_WIDTH-1:IDX+2]),
        .wr_target_i (ex_target),
        .wr_kind_i   (ex_kind)
    );

    assign if_pht_idx   = if_pc[GHR_BITS+1:2] ^ ghr_q;
    assign pred_pht_idx = if_pht_idx;
    assign pred_taken   = btb_hit && ((btb_kind != KIND_BR) || ctr_predicts_taken(pht_q[if_pht_idx]));
    assign pred_next_pc = pred_taken ? btb_target : if_pc + PC_WIDTH'(4);

    assign pc_4    = ex_pc + PC_WIDTH'(4);
    assign is_ctrl = ex_is_branch | ex_is_jal | ex_is_jalr;

    always_comb begin
        ex_target = pc_4;
        ex_taken  = 1'b0;
        ex_kind   = KIND_BR;
        if (ex_is_jal) begin
            ex_target = ex_pc_imm;
            ex_taken  = 1'b1;
            ex_kind   = KIND_JAL;
        end else if (ex_is_jalr) begin
            ex_target = ex_alu_result & JALR_MASK;
            ex_taken  = 1'b1;
            ex_kind   = KIND_JALR;
        end else if (ex_is_branch && ex_bcond) begin
            ex_target = ex_pc_imm;
            ex_taken  = 1'b1;
        end
    end

    // A bubble still reports pc+4 so the fetch mux always has a sane value.
    assign correct_pc        = ex_valid ? ex_target : pc_4;
    assign is_actually_taken = ex_valid & ex_taken;
    assign pc_src            = ex_valid & is_ctrl & (ex_next_inst_pc != ex_target);
    assign rd_data           = (ex_valid & (ex_is_jal | ex_is_jalr)) ? pc_4 : '0;
    assign mispredict_count  = cnt_q;
    assign do_update         = ex_valid & is_ctrl;

    always_comb begin
        ghr_d = ghr_q;
        cnt_d = cnt_q;
        if (do_update && ex_is_branch) begin
            ghr_d = {ghr_q[GHR_BITS-2:0], ex_bcond};
        end
        if (pc_src && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht_q[i] <= PHT_RESET;
            end
            ghr_q <= '0;
            cnt_q <= '0;
        end else begin
            if (do_update && ex_is_branch) begin
                pht_q[ex_pht_idx] <= ctr_update(pht_q[ex_pht_idx], ex_bcond);
            end
            ghr_q <= ghr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// tb/tb_gshare_branch_predictor.sv - self-checking bench with a behavioural predictor model
module tb_gshare_branch_predictor;

    localparam int K_NONE = 0, K_BR = 1, K_JAL = 2, K_JALR = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc, pred_next_pc;
    logic        pred_taken;
    logic [5:0]  pred_pht_idx;
    logic        ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, ex_bcond;
    logic [31:0] ex_pc, ex_pc_imm, ex_alu_result, ex_next_inst_pc;
    logic [5:0]  ex_pht_idx;
    logic        pc_src, is_actually_taken;
    logic [31:0] correct_pc, rd_data, mispredict_count;
    int          ex_kind;
    int          n_checks = 0;
    int          n_pass = 0;

    bit          m_valid  [32];
    logic [31:0] m_tag    [32];
    logic [31:0] m_target [32];
    int          m_kind   [32];
    int          m_pht    [64];
    int          m_ghr;
    longint      m_cnt;

    always #5 clk = ~clk;

    gshare_branch_predictor dut (
        .clk(clk), .reset(reset), .if_pc(if_pc), .pred_next_pc(pred_next_pc),
        .pred_taken(pred_taken), .pred_pht_idx(pred_pht_idx), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal),
        .ex_is_jalr(ex_is_jalr), .ex_bcond(ex_bcond), .ex_pc_imm(ex_pc_imm),
        .ex_alu_result(ex_alu_result), .ex_pht_idx(ex_pht_idx),
        .ex_next_inst_pc(ex_next_inst_pc), .pc_src(pc_src), .correct_pc(correct_pc),
        .is_actually_taken(is_actually_taken), .rd_data(rd_data),
        .mispredict_count(mispredict_count)
    );

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
        for (int i = 0; i < 64; i++) m_pht[i] = 1;
        m_ghr = 0;
        m_cnt = 0;
    endtask

    function automatic int gidx(input logic [31:0] pc);
        return int'((pc >> 2) & 32'd63) ^ m_ghr;
    endfunction

    function automatic void model_predict(input logic [31:0] pc, output logic [31:0] nxt, output logic tk);
        int i;
        i  = int'((pc >> 2) & 32'd31);
        tk = m_valid[i] && (m_tag[i] == (pc >> 7)) && (m_kind[i] != K_BR || m_pht[gidx(pc)] >= 2);
        nxt = tk ? m_target[i] : pc + 32'd4;
    endfunction

    function automatic void model_resolve(output logic [31:0] cpc, output logic src,
                                          output logic tk, output logic [31:0] rd);
        logic [31:0] pc4;
        pc4 = ex_pc + 32'd4;
        cpc = pc4; src = 1'b0; tk = 1'b0; rd = 32'd0;
        if (!ex_valid) return;
        case (ex_kind)
            K_BR:    begin tk = ex_bcond; cpc = ex_bcond ? ex_pc_imm : pc4; end
            K_JAL:   begin tk = 1'b1; cpc = ex_pc_imm; rd = pc4; end
            K_JALR:  begin tk = 1'b1; cpc = ex_alu_result & 32'hFFFF_FFFE; rd = pc4; end
            default: ;
        endcase
        src = (ex_kind != K_NONE) && (ex_next_inst_pc != cpc);
    endfunction

    task automatic model_update();
        logic [31:0] cpc, rd;
        logic src, tk;
        int i;
        if (!ex_valid || ex_kind == K_NONE) return;
        model_resolve(cpc, src, tk, rd);
        if (ex_kind == K_BR) begin
            if (ex_bcond) m_pht[ex_pht_idx] = (m_pht[ex_pht_idx] == 3) ? 3 : m_pht[ex_pht_idx] + 1;
            else          m_pht[ex_pht_idx] = (m_pht[ex_pht_idx] == 0) ? 0 : m_pht[ex_pht_idx] - 1;
            m_ghr = ((m_ghr << 1) | int'(ex_bcond)) & 63;
        end
        if (tk) begin
            i = int'((ex_pc >> 2) & 32'd31);
            m_valid[i] = 1'b1; m_tag[i] = ex_pc >> 7; m_target[i] = cpc; m_kind[i] = ex_kind;
        end
        if (src && m_cnt < 64'hFFFF_FFFF) m_cnt++;
    endtask

    task automatic set_ex(input logic v, input logic [31:0] pc, input int k, input logic bc,
                          input logic [31:0] imm, input logic [31:0] alu, input logic [5:0] pidx,
                          input logic [31:0] nxt);
        ex_valid = v; ex_pc = pc; ex_kind = k; ex_bcond = bc;
        ex_is_branch = (k == K_BR); ex_is_jal = (k == K_JAL); ex_is_jalr = (k == K_JALR);
        ex_pc_imm = imm; ex_alu_result = alu; ex_pht_idx = pidx; ex_next_inst_pc = nxt;
    endtask

    task automatic idle_ex();
        set_ex(1'b0, 32'h0, K_NONE, 1'b0, 32'h0, 32'h0, 6'd0, 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_ex();
        if_pc = 32'h100;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        n_checks++; if (pred_next_pc !== 32'h104) $display("FAIL reset_next got %h want %h", pred_next_pc, 32'h104); else n_pass++;
        n_checks++; if (pred_taken !== 1'b0) $display("FAIL reset_taken got %b want 0", pred_taken); else n_pass++;
        n_checks++; if (mispredict_count !== 32'd0) $display("FAIL reset_count got %0d want 0", mispredict_count); else n_pass++;
        n_checks++; if (pred_pht_idx !== 6'd0) $display("FAIL reset_pht_idx got %0d want 0", pred_pht_idx); else n_pass++;
        n_checks++; if (pc_src !== 1'b0 || correct_pc !== 32'h4) $display("FAIL reset_resolve got %b/%h want 0/4", pc_src, correct_pc); else n_pass++;
    endtask

    task automatic test_jal();
        set_ex(1'b1, 32'h100, K_JAL, 1'b0, 32'h200, 32'h0, 6'd0, 32'h104);
        #1;
        n_checks++; if (pc_src !== 1'b1) $display("FAIL jal_pc_src got %b want 1", pc_src); else n_pass++;
        n_checks++; if (correct_pc !== 32'h200) $display("FAIL jal_correct got %h want %h", correct_pc, 32'h200); else n_pass++;
        n_checks++; if (rd_data !== 32'h104) $display("FAIL jal_rd got %h want %h", rd_data, 32'h104); else n_pass++;
        n_checks++; if (is_actually_taken !== 1'b1) $display("FAIL jal_taken got %b want 1", is_actually_taken); else n_pass++;
        step();
        idle_ex();
        if_pc = 32'h100;
        #1;
        n_checks++; if (pred_next_pc !== 32'h200 || pred_taken !== 1'b1) $display("FAIL jal_predict got %h/%b want 200/1", pred_next_pc, pred_taken); else n_pass++;
        n_checks++; if (mispredict_count !== 32'd1) $display("FAIL jal_count got %0d want 1", mispredict_count); else n_pass++;
    endtask

    task automatic saturate_history();
        repeat (6) begin
            set_ex(1'b1, 32'h1000, K_BR, 1'b1, 32'h1100, 32'h0, 6'd0, 32'h1100);
            step();
        end
        idle_ex();
    endtask

    task automatic test_branch_training();
        saturate_history();
        if_pc = 32'h40;
        #1;
        n_checks++; if (pred_pht_idx !== 6'd47) $display("FAIL br_pht_idx got %0d want 47", pred_pht_idx); else n_pass++;
        n_checks++; if (pred_taken !== 1'b0) $display("FAIL br_cold_taken got %b want 0", pred_taken); else n_pass++;
        for (int k = 0; k < 2; k++) begin
            set_ex(1'b1, 32'h40, K_BR, 1'b1, 32'h80, 32'h0, 6'd47, 32'h44);
            #1;
            n_checks++; if (pc_src !== 1'b1 || correct_pc !== 32'h80) $display("FAIL br_train%0d got %b/%h want 1/80", k, pc_src, correct_pc); else n_pass++;
            step();
        end
        idle_ex();
        #1;
        n_checks++; if (pred_taken !== 1'b1 || pred_next_pc !== 32'h80) $display("FAIL br_strong got %b/%h want 1/80", pred_taken, pred_next_pc); else n_pass++;
        set_ex(1'b1, 32'h40, K_BR, 1'b0, 32'h80, 32'h0, 6'd47, 32'h80);
        #1;
        n_checks++; if (pc_src !== 1'b1 || correct_pc !== 32'h44 || is_actually_taken !== 1'b0) $display("FAIL br_nt got %b/%h/%b want 1/44/0", pc_src, correct_pc, is_actually_taken); else n_pass++;
        step();
        saturate_history();
        if_pc = 32'h40;
        #1;
        n_checks++; if (pred_taken !== 1'b1 || pred_next_pc !== 32'h80) $display("FAIL br_weak_taken got %b/%h want 1/80", pred_taken, pred_next_pc); else n_pass++;
        n_checks++; if (mispredict_count !== 32'd4) $display("FAIL br_count got %0d want 4", mispredict_count); else n_pass++;
    endtask

    task automatic test_jalr();
        set_ex(1'b1, 32'h180, K_JALR, 1'b0, 32'h0, 32'h211, 6'd0, 32'h184);
        #1;
        n_checks++; if (correct_pc !== 32'h210 || rd_data !== 32'h184 || pc_src !== 1'b1) $display("FAIL jalr1 got %h/%h/%b want 210/184/1", correct_pc, rd_data, pc_src); else n_pass++;
        step();
        idle_ex();
        if_pc = 32'h180;
        #1;
        n_checks++; if (pred_next_pc !== 32'h210) $display("FAIL jalr1_predict got %h want %h", pred_next_pc, 32'h210); else n_pass++;
        set_ex(1'b1, 32'h180, K_JALR, 1'b0, 32'h0, 32'h301, 6'd0, 32'h210);
        #1;
        n_checks++; if (correct_pc !== 32'h300 || pc_src !== 1'b1) $display("FAIL jalr2 got %h/%b want 300/1", correct_pc, pc_src); else n_pass++;
        step();
        idle_ex();
        #1;
        n_checks++; if (pred_next_pc !== 32'h300) $display("FAIL jalr2_predict got %h want %h", pred_next_pc, 32'h300); else n_pass++;
    endtask

    task automatic test_stall();
        longint saved;
        saved = m_cnt;
        set_ex(1'b0, 32'h240, K_BR, 1'b1, 32'h400, 32'h0, 6'd5, 32'h244);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if (pc_src !== 1'b0 || is_actually_taken !== 1'b0 || rd_data !== 32'd0 || correct_pc !== 32'h244)
                $display("FAIL stall%0d got %b/%b/%h/%h want 0/0/0/244", c, pc_src, is_actually_taken, rd_data, correct_pc); else n_pass++;
            step();
        end
        n_checks++; if (mispredict_count !== 32'(saved)) $display("FAIL stall_count got %0d want %0d", mispredict_count, saved); else n_pass++;
        ex_valid = 1'b1;
        #1;
        n_checks++; if (pc_src !== 1'b1) $display("FAIL stall_release got %b want 1", pc_src); else n_pass++;
        step();
        idle_ex();
        #1;
        n_checks++; if (mispredict_count !== 32'(saved + 1)) $display("FAIL stall_count_once got %0d want %0d", mispredict_count, saved + 1); else n_pass++;
    endtask

    task automatic test_alias();
        set_ex(1'b1, 32'h000, K_JAL, 1'b0, 32'h400, 32'h0, 6'd0, 32'h004);
        step();
        set_ex(1'b1, 32'h080, K_JAL, 1'b0, 32'h500, 32'h0, 6'd0, 32'h084);
        step();
        idle_ex();
        if_pc = 32'h000;
        #1;
        n_checks++; if (pred_next_pc !== 32'h004 || pred_taken !== 1'b0) $display("FAIL alias_evicted got %h/%b want 4/0", pred_next_pc, pred_taken); else n_pass++;
        if_pc = 32'h080;
        #1;
        n_checks++; if (pred_next_pc !== 32'h500) $display("FAIL alias_new got %h want %h", pred_next_pc, 32'h500); else n_pass++;
    endtask

    function automatic logic [31:0] pool_pc();
        return (32'($urandom_range(0, 1)) << 8) | (32'($urandom_range(0, 63)) << 2);
    endfunction

    task automatic test_random();
        logic [31:0] p, imm, alu, nxt, e_nxt, e_cpc, e_rd;
        logic e_tk, e_src, e_atk;
        int k, errs;
        errs = 0;
        for (int it = 0; it < 300; it++) begin
            p   = pool_pc();
            imm = pool_pc();
            alu = pool_pc() | 32'($urandom_range(0, 1));
            k   = int'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0:       nxt = p + 32'd4;
                1:       nxt = imm;
                default: nxt = alu & 32'hFFFF_FFFE;
            endcase
            set_ex($urandom_range(0, 3) != 0, p, k, 1'($urandom_range(0, 1)), imm, alu,
                   ($urandom_range(0, 3) != 0) ? 6'(gidx(p)) : 6'($urandom_range(0, 63)), nxt);
            if_pc = pool_pc();
            #1;
            model_predict(if_pc, e_nxt, e_tk);
            model_resolve(e_cpc, e_src, e_atk, e_rd);
            n_checks++; if (pred_next_pc !== e_nxt || pred_taken !== e_tk) begin errs++; $display("FAIL rnd_predict it=%0d pc=%h got %h/%b want %h/%b", it, if_pc, pred_next_pc, pred_taken, e_nxt, e_tk); end else n_pass++;
            n_checks++; if (pred_pht_idx !== 6'(gidx(if_pc))) begin errs++; $display("FAIL rnd_pht_idx it=%0d got %0d want %0d", it, pred_pht_idx, gidx(if_pc)); end else n_pass++;
            n_checks++; if (pc_src !== e_src || correct_pc !== e_cpc) begin errs++; $display("FAIL rnd_resolve it=%0d got %b/%h want %b/%h", it, pc_src, correct_pc, e_src, e_cpc); end else n_pass++;
            n_checks++; if (is_actually_taken !== e_atk || rd_data !== e_rd) begin errs++; $display("FAIL rnd_link it=%0d got %b/%h want %b/%h", it, is_actually_taken, rd_data, e_atk, e_rd); end else n_pass++;
            n_checks++; if (mispredict_count !== 32'(m_cnt)) begin errs++; $display("FAIL rnd_count it=%0d got %0d want %0d", it, mispredict_count, m_cnt); end else n_pass++;
            if (errs > 20) break;
            step();
        end
        idle_ex();
    endtask

    task automatic test_mid_reset();
        set_ex(1'b1, 32'h080, K_JAL, 1'b0, 32'h600, 32'h0, 6'd0, 32'h084);
        step();
        idle_ex();
        if_pc = 32'h080;
        #1;
        n_checks++; if (pred_next_pc !== 32'h600) $display("FAIL midrst_before got %h want %h", pred_next_pc, 32'h600); else n_pass++;
        #1 reset = 1'b0;
        #1;
        model_reset();
        n_checks++; if (pred_next_pc !== 32'h084 || pred_taken !== 1'b0) $display("FAIL midrst_predict got %h/%b want 84/0", pred_next_pc, pred_taken); else n_pass++;
        n_checks++; if (mispredict_count !== 32'd0) $display("FAIL midrst_count got %0d want 0", mispredict_count); else n_pass++;
        #2 reset = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_jal();
        test_branch_training();
        test_jalr();
        test_stall();
        test_alias();
        test_random();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gshare_branch_predictor.md
# gshare_branch_predictor

Parametrised fetch-side predictor plus EX-stage resolver for the pipelined CPU. It combines a direct-mapped BTB, a gshare pattern history table (PHT) of 2-bit counters, and a global history register (GHR). IF gets a combinational next-PC prediction. EX gets mispredict detection, the correct PC and link data. This block replaces the purely combinational branch resolver.

## Interface
- PC_WIDTH, 32, width of all PC/address ports
- BTB_ENTRIES, 32, BTB entries; power of two, ≥ 2
- GHR_BITS, 6, history length; PHT has 2**GHR_BITS entries

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; all state cleared while low
- if_pc  in  PC_WIDTH  PC being fetched
- pred_next_pc  out  PC_WIDTH  predicted PC after if_pc
- pred_taken  out  1  prediction redirected fetch
- pred_pht_idx  out  GHR_BITS  PHT index used; carried down the pipe with the instruction
- ex_valid  in  1  EX holds a real, non-stalled instruction this cycle
- ex_pc  in  PC_WIDTH  PC of the EX instruction
- ex_is_branch / ex_is_jal / ex_is_jalr  in  1 each  control type; at most one high
- ex_bcond  in  1  ALU branch condition
- ex_pc_imm  in  PC_WIDTH  pc+imm
- ex_alu_result  in  PC_WIDTH  rs1+imm (jalr target; bit 0 cleared internally)
- ex_pht_idx  in  GHR_BITS  pred_pht_idx returned from IF
- ex_next_inst_pc  in  PC_WIDTH  PC of the instruction currently behind EX
- pc_src  out  1  mispredict; flush IF/ID and load correct_pc
- correct_pc  out  PC_WIDTH  architecturally correct next PC
- is_actually_taken  out  1  resolved direction
- rd_data  out  PC_WIDTH  link value ex_pc+4 for jal/jalr, else 0
- mispredict_count  out  32  saturating count of pc_src events

## Operation
- Index: IDX = log2(BTB_ENTRIES), from pc[IDX+1:2]. Tag = pc[PC_WIDTH-1:IDX+2].
- BTB entry: valid, tag, target, kind (BR/JAL/JALR).
- gshare index = pc[GHR_BITS+1:2] XOR ghr.
- Predict (combinational on if_pc):
  - BTB hit with kind JAL/JALR: taken, next = target.
  - BTB hit with kind BR: taken iff PHT[idx][1] == 1.
  - Miss: not taken, next = if_pc+4.
  - pred_pht_idx is always driven.
- Resolve (combinational, EX):
  - pc_4 = ex_pc+4.
  - branch: correct = bcond ? pc_imm : pc_4.
  - jal: correct = pc_imm.
  - jalr: correct = alu_result & ~1.
  - Non-control: correct = pc_4 and pc_src = 0.
  - Control: pc_src = ex_valid & (ex_next_inst_pc != correct_pc).
  - All resolve outputs are 0 when ex_valid = 0, except correct_pc = pc_4.
- Update (at the clock edge, only when ex_valid and the instruction is control):
  - Branch: PHT[ex_pht_idx] saturating ±1 (00..11) by bcond. GHR = {ghr[GHR_BITS-2:0], bcond}.
  - Taken control instruction: write BTB[idx] = {1, tag, correct_pc, kind}. Overwrite on conflict.
  - Not-taken branch: BTB unchanged.
  - pc_src: mispredict_count++, saturating at 2^32-1.
- Reset values:
  - BTB valid bits = 0.
  - PHT = 2'b01 (weakly not taken).
  - GHR = 0; count = 0.
  - Hence pred_next_pc = if_pc+4 and pred_taken = 0.

## Timing
- Prediction and resolution: zero-latency combinational.
- State updates: visible to the prediction one cycle after the update edge.
- Same-cycle read and write to the same entry: IF sees the old value; no bypass.
- ex_valid = 0 (bubble/stall): no state change. Repeated stall cycles never double-count or double-train.
- Reset asserted mid-run clears all state immediately. First update is at the first rising edge after deassertion.
- GHR is updated non-speculatively at resolution only. In-flight indices use the older history; this is accepted.

## Structure
- Shared header alongside opcodes.v holds:
  - counter encodings SNT/WNT/WT/ST
  - PHT reset value
  - BTB kind codes
- One sub-module, btb_array, covers the BTB storage, tag compare and write port.
- PHT, GHR, resolver and counter stay in the top module.

## Test plan
- Reset release, if_pc = 0x100 → pred_next_pc = 0x104, pred_taken = 0, mispredict_count = 0.
- jal at 0x100, pc_imm = 0x200, ex_next_inst_pc = 0x104 → pc_src = 1, correct_pc = 0x200, rd_data = 0x104. The next cycle, if_pc = 0x100 predicts 0x200.
- Branch at 0x40 taken 2× with fixed history:
  - PHT 01→10→11.
  - Third fetch predicts taken.
  - Then a not-taken resolution gives pc_src = 1, correct_pc = 0x44, counter 10.
- jalr with alu_result = 0x301 → correct_pc = 0x300. BTB target updated to 0x300 after two different targets.
- ex_valid = 0 for 3 cycles with a mispredicting branch held → no count or PHT change. Count +1 once valid.
- Two PCs 0x000 and 0x080 with BTB_ENTRIES = 32 alias → second allocation evicts the first; 0x000 then predicts +4.
